// File: rtl/eject_buffer.sv
// eject_buffer: ejection FIFO between the router local port and the PE.
// ejStall rises early so the allocator deflects rather than drops.
`ifndef NUM_CHANNEL
`define NUM_CHANNEL 5
`endif
`ifndef WIDTH_PORT
`define WIDTH_PORT 16
`endif

module eject_buffer #(
  parameter int DEPTH = 4,
  parameter int SLACK = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [`NUM_CHANNEL-1:0] localVector,
  input  logic [`WIDTH_PORT-1:0]  localFlit,
  output logic                    ejStall,
  output logic [`WIDTH_PORT-1:0]  peFlit,
  output logic                    peValid,
  input  logic                    peReady,
  output logic                    overflow,
  output logic                    multiHot,
  output logic [7:0]              dropCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_C = CW'(DEPTH - SLACK);

  logic [`WIDTH_PORT-1:0] mem_q [DEPTH];

  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          mh_q, mh_d;
  logic [7:0]    drop_q, drop_d;

  logic push, pop, full, wr_en, drop, multi;

  assign peValid   = (cnt_q != '0);
  assign peFlit    = mem_q[rd_q];
  assign ejStall   = (cnt_q >= STALL_C);
  assign overflow  = ovf_q;
  assign multiHot  = mh_q;
  assign dropCount = drop_q;

  always_comb begin
    push  = |localVector;
    pop   = peValid && peReady;
    full  = (cnt_q == FULL_C);
    // a full queue still accepts a flit when the head leaves this cycle
    wr_en = push && (!full || pop);
    drop  = push && full && !pop;
    multi = (localVector
             & (localVector - `NUM_CHANNEL'(1))) != '0;

    rd_d  = pop   ? rd_q + AW'(1) : rd_q;
    wr_d  = wr_en ? wr_q + AW'(1) : wr_q;
    cnt_d = cnt_q;
    if (wr_en && !pop)
      cnt_d = cnt_q + CW'(1);
    else if (!wr_en && pop)
      cnt_d = cnt_q - CW'(1);

    ovf_d  = ovf_q | drop;
    mh_d   = mh_q | multi;
    drop_d = drop_q;
    if (drop && drop_q != 8'hFF)
      drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      mh_q   <= 1'b0;
      drop_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      mh_q   <= mh_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_en)
      mem_q[wr_q] <= localFlit;
  end

endmodule

// File: doc/eject_buffer.md
EJECT_BUFFER -- requirements
Module: eject_buffer

Interface
REQ-001 Parameter DEPTH, default 4: FIFO entries; power of two, 2..16.
REQ-002 Parameter SLACK, default 1: free entries held in reserve before stall; 1..DEPTH-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 localVector  input  `NUM_CHANNEL  one-hot port-allocator eject vector; nonzero = flit ejected this cycle.
REQ-006 localFlit  input  `WIDTH_PORT  ejected flit from the ejection mux, same cycle as localVector.
REQ-007 ejStall  output  1  to port allocator: high = do not eject next cycle, deflect instead.
REQ-008 peFlit  output  `WIDTH_PORT  head-of-queue flit to local PE.
REQ-009 peValid  output  1  peFlit valid.
REQ-010 peReady  input  1  PE accepts peFlit this cycle.
REQ-011 overflow  output  1  sticky: a flit was dropped because the FIFO was full.
REQ-012 multiHot  output  1  sticky: localVector seen with more than one bit set.
REQ-013 dropCount  output  8  saturating count of dropped flits.

Function
REQ-014 push = (|localVector); pop = peValid && peReady.
REQ-015 Storage: DEPTH x `WIDTH_PORT circular buffer, read/write pointers of log2(DEPTH) bits wrapping modulo DEPTH, occupancy count of log2(DEPTH)+1 bits.
REQ-016 peValid = (count != 0); peFlit = entry at read pointer, driven from registers (no combinational path from localFlit or localVector).
REQ-017 Push latency: flit pushed in cycle N is visible on peFlit with peValid high in cycle N+1 at the earliest.
REQ-018 Pop: on pop, read pointer advances by one; peFlit shows next entry the following cycle.
REQ-019 ejStall = (count >= DEPTH - SLACK), combinational from registered count only.
REQ-020 Push with count < DEPTH: flit written at write pointer, write pointer advances, count increments (unless simultaneous pop).
REQ-021 Simultaneous push and pop, count between 1 and DEPTH: both performed, count unchanged.
REQ-022 Push with count == DEPTH and pop same cycle: push accepted, count stays DEPTH.
REQ-023 Push with count == DEPTH and no pop: flit discarded, pointers and count unchanged, overflow set, dropCount increments.
REQ-024 dropCount saturates at 255; never wraps.
REQ-025 Pop with count == 0 is impossible by REQ-014 (peValid low); peReady is ignored when empty.
REQ-026 Push with count == 0 and peReady high: no bypass; flit stored, popped no earlier than next cycle.
REQ-027 multiHot set when localVector has two or more bits set; flit still pushed normally (ejection mux has already resolved priority).
REQ-028 overflow and multiHot remain set until reset.
REQ-029 localFlit content is not inspected; all `WIDTH_PORT bits stored verbatim.

Reset
REQ-030 While reset is high at a rising edge: pointers, count, overflow, multiHot, dropCount cleared to 0; push and pop ignored that cycle.
REQ-031 After reset: peValid=0, ejStall=0, overflow=0, multiHot=0, dropCount=0; peFlit value don't-care while peValid=0.
REQ-032 Reset asserted mid-operation discards all stored flits; no flit emitted after reset deasserts until a new push.
REQ-033 Storage array contents need no reset.

Verification
REQ-034 Single flit: reset, push 0xA5 on localVector=00001, peReady=0 -> next cycle peValid=1, peFlit=0xA5, ejStall=0; peReady=1 one cycle -> peValid=0 after.
REQ-035 Fill/stall (DEPTH=4, SLACK=1): push 1,2,3 in consecutive cycles, peReady=0 -> ejStall rises the cycle after third push (count=3); drain returns 1,2,3 in order, ejStall falls when count=2.
REQ-036 Overflow: fill to 4, push 5th with peReady=0 -> overflow=1, dropCount=1, drain yields exactly 4 flits; repeat 300 drops -> dropCount=255.
REQ-037 Full with simultaneous push/pop: count=4, push 0x77 with peReady=1 -> count stays 4, overflow stays 0, 0x77 emerges 4th after the popped head.
REQ-038 Wrap and reset: 10 push/pop cycles wrap pointers with correct order; localVector=00110 -> multiHot=1; assert reset with 3 queued -> peValid=0, all flags 0 next cycle.
